uart_rx: RTL

// Serial-to-parallel UART receiver, the consumer of the uart_tx serial line in the

---
 rtl/uart_rx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized serial input, mid-bit sampling at CLK_PER_BIT
// clocks per bit, one-cycle pulses for a good byte, a framing error or a parity error.
module uart_rx #(
   parameter int DATA_BIT_COUNT   = 8,
   parameter int PARITY_BIT_COUNT = 0,
   parameter int PARITY_ODD       = 0,
   parameter int CLK_PER_BIT      = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      serial,
   output logic [DATA_BIT_COUNT-1:0] data,
   output logic                      data_valid,
   output logic                      frame_err,
   output logic                      parity_err,
   output logic                      busy
);

   localparam int CW = $clog2(CLK_PER_BIT) + 1;
   localparam int IW = (DATA_BIT_COUNT > 1) ? $clog2(DATA_BIT_COUNT) : 1;
   localparam logic [CW-1:0] HALF_M1  = CW'(CLK_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(CLK_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BIT_COUNT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

   state_t                    state;
   logic [CW-1:0]             cnt;
   logic [IW-1:0]             bit_idx;
   logic [DATA_BIT_COUNT-1:0] shift_r;
   logic                      par_r;
   logic                      sync_p0;
   logic                      sync_p1;
   logic                      rx;

   // A frame without a parity bit always passes the parity check.
   function automatic logic parity_ok(input logic [DATA_BIT_COUNT-1:0] d, input logic p);
      if (PARITY_BIT_COUNT == 0)
         return 1'b1;
      return ((^d) ^ (PARITY_ODD != 0)) == p;
   endfunction

   // Stage p0/p1: metastability synchronizer; idles high like the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
      end else begin
         sync_p0 <= serial;
         sync_p1 <= sync_p0;
      end
   end

   assign rx = sync_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shift_r    <= '0;
         par_r      <= 1'b0;
         data       <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         busy       <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         case (state)
            IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
               if (!rx) begin
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (cnt == HALF_M1) begin
                  cnt <= '0;
                  if (!rx) begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == FULL_M1) begin
                  cnt              <= '0;
                  shift_r[bit_idx] <= rx;
                  if (bit_idx == LAST_BIT) begin
                     bit_idx <= '0;
                     state   <= (PARITY_BIT_COUNT == 1) ? PARITY : STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PARITY: begin
               if (cnt == FULL_M1) begin
                  cnt   <= '0;
                  par_r <= rx;
                  state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               // Exit at mid stop bit so a back-to-back start edge is not missed.
               if (cnt == FULL_M1) begin
                  cnt <= '0;
                  if (!rx) begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end else if (parity_ok(shift_r, par_r)) begin
                     data       <= shift_r;
                     data_valid <= 1'b1;
                     state      <= IDLE;
                     busy       <= 1'b0;
                  end else begin
                     parity_err <= 1'b1;
                     state      <= IDLE;
                     busy       <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BREAK: begin
               if (rx) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
